// File: rtl/load_store_unit.sv
// Data-memory access stage: turns an ALU effective address into a req/ack bus cycle,
// generates byte lanes, flags bad accesses and bus timeouts, and extends load data.
module load_store_unit #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         we,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic [3:0]   mem_be,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack
);

    localparam int          CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            legal_s;
    logic            aligned_s;
    logic            accept_s;
    logic            ack_s;
    logic            err_s;
    logic            busy_s;
    logic            we_r;
    logic [2:0]      funct3_r;
    logic [1:0]      off_r;
    logic [CW-1:0]   cnt_r;
    logic            done_r;
    logic            err_r;
    logic [N-1:0]    rdata_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [N-1:0]    mem_addr_r;
    logic [N-1:0]    mem_wdata_r;
    logic [3:0]      mem_be_r;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_enable = 4'b0001 << off;
            2'b01:   lane_enable = 4'b0011 << off;
            2'b10:   lane_enable = 4'b1111;
            default: lane_enable = 4'b0000;
        endcase
    endfunction

    function automatic logic [N-1:0] replicate_wdata(input logic [1:0] size, input logic [N-1:0] d);
        case (size)
            2'b00:   replicate_wdata = N'({4{d[7:0]}});
            2'b01:   replicate_wdata = N'({2{d[15:0]}});
            default: replicate_wdata = d;
        endcase
    endfunction

    // Load data arrives word-aligned; shift the addressed lane down before extending.
    function automatic logic [N-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [N-1:0] d);
        logic [N-1:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{(N-8){sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{(N-16){sh[15]}}, sh[15:0]};
            3'b100:  load_extend = {{(N-8){1'b0}}, sh[7:0]};
            3'b101:  load_extend = {{(N-16){1'b0}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // Encoding legality and natural-alignment check of the incoming request.
    always_comb begin
        legal_s   = 1'b0;
        aligned_s = 1'b0;
        if (we) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b011, 3'b110, 3'b111: legal_s = 1'b0;
                default:                legal_s = 1'b1;
            endcase
        end
        case (funct3[1:0])
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = ~addr[0];
            2'b10:   aligned_s = (addr[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        ack_s    = 1'b0;
        err_s    = 1'b0;
        busy_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    busy_s = 1'b1;
                    if (legal_s && aligned_s) begin
                        state_s  = BUS;
                        accept_s = 1'b1;
                    end else begin
                        state_s = RESP;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                busy_s = 1'b1;
                if (mem_ack) begin
                    state_s = RESP;
                    ack_s   = 1'b1;
                end else if (cnt_r == LAST) begin
                    state_s = RESP;
                    err_s   = 1'b1;
                end else begin
                    state_s = BUS;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, completion pulse, error flag and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == RESP);
            err_r   <= err_s;
            cnt_r   <= ((state_r == BUS) && (state_s == BUS)) ? cnt_r + CW'(1) : '0;
        end
    end

    // Latched access attributes used when the response returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            off_r    <= 2'b00;
        end else if (accept_s) begin
            we_r     <= we;
            funct3_r <= funct3;
            off_r    <= addr[1:0];
        end
    end

    // Bus request fields; held stable for the whole BUS state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= 4'b0000;
        end else begin
            mem_req_r <= accept_s | ((state_r == BUS) && (state_s == BUS));
            if (accept_s) begin
                mem_we_r    <= we;
                mem_addr_r  <= {addr[N-1:2], 2'b00};
                mem_wdata_r <= replicate_wdata(funct3[1:0], wdata);
                mem_be_r    <= lane_enable(funct3[1:0], addr[1:0]);
            end
        end
    end

    // Load result: only a successfully acknowledged load updates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (ack_s && !we_r) begin
            rdata_r <= load_extend(funct3_r, off_r, mem_rdata);
        end
    end

    assign busy      = busy_s;
    assign done      = done_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors, timeout and reset abort.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks;
    int errors;

    load_store_unit #(.N(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input logic s, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        start  = s;
        we     = w;
        funct3 = f;
        addr   = a;
        wdata  = d;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        setop(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // LW, zero-wait ack
        setop(1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'h0);
        #1;
        chk("lw_busy_c0", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        chk("lw_req_c1", {31'd0, mem_req}, 32'd1);
        chk("lw_addr", mem_addr, 32'h1000_0008);
        chk("lw_be", {28'd0, mem_be}, 32'h0000_000F);
        chk("lw_we", {31'd0, mem_we}, 32'd0);
        chk("lw_busy_c1", {31'd0, busy}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("lw_done_c2", {31'd0, done}, 32'd1);
        chk("lw_err_c2", {31'd0, err}, 32'd0);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_req_c2", {31'd0, mem_req}, 32'd0);
        chk("lw_busy_c2", {31'd0, busy}, 32'd0);
        tick();
        chk("lw_done_c3", {31'd0, done}, 32'd0);

        // LB then back-to-back LBU at offset 3
        setop(1'b1, 1'b0, 3'b000, 32'h2000_0003, 32'h0);
        tick();
        start = 1'b0;
        chk("lb_addr", mem_addr, 32'h2000_0000);
        chk("lb_be", {28'd0, mem_be}, 32'h0000_0008);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_0011;
        tick();
        mem_ack = 1'b0;
        chk("lb_done", {31'd0, done}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        setop(1'b1, 1'b0, 3'b100, 32'h2000_0003, 32'h0);
        #1;
        chk("resp_busy_ignores_start", {31'd0, busy}, 32'd0);
        tick();
        chk("lbu_idle_busy", {31'd0, busy}, 32'd1);
        chk("lbu_idle_done", {31'd0, done}, 32'd0);
        tick();
        start = 1'b0;
        chk("lbu_req", {31'd0, mem_req}, 32'd1);
        chk("lbu_be", {28'd0, mem_be}, 32'h0000_0008);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("lbu_done", {31'd0, done}, 32'd1);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        tick();

        // LH at offset 2, sign-extended
        setop(1'b1, 1'b0, 3'b001, 32'h2000_0006, 32'h0);
        tick();
        start = 1'b0;
        chk("lh_be", {28'd0, mem_be}, 32'h0000_000C);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8001_1234;
        tick();
        mem_ack = 1'b0;
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        tick();

        // SH with three wait cycles
        setop(1'b1, 1'b1, 3'b001, 32'h3000_0002, 32'h1234_ABCD);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sh_req", {31'd0, mem_req}, 32'd1);
            chk("sh_we", {31'd0, mem_we}, 32'd1);
            chk("sh_be", {28'd0, mem_be}, 32'h0000_000C);
            chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
            chk("sh_addr", mem_addr, 32'h3000_0000);
            chk("sh_done_wait", {31'd0, done}, 32'd0);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("sh_done_c5", {31'd0, done}, 32'd1);
        chk("sh_err", {31'd0, err}, 32'd0);
        chk("sh_rdata_held", rdata, 32'hFFFF_8001);
        tick();

        // Misaligned LW: no bus traffic
        setop(1'b1, 1'b0, 3'b010, 32'h1000_0002, 32'h0);
        #1;
        chk("mis_busy_c0", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_done", {31'd0, done}, 32'd1);
        chk("mis_err", {31'd0, err}, 32'd1);
        tick();
        chk("mis_done_c2", {31'd0, done}, 32'd0);
        chk("mis_err_c2", {31'd0, err}, 32'd0);
        chk("mis_req_c2", {31'd0, mem_req}, 32'd0);

        // Illegal store encoding funct3=100
        setop(1'b1, 1'b1, 3'b100, 32'h1000_0000, 32'h0);
        tick();
        start = 1'b0;
        chk("ill_req", {31'd0, mem_req}, 32'd0);
        chk("ill_done", {31'd0, done}, 32'd1);
        chk("ill_err", {31'd0, err}, 32'd1);
        tick();

        // Ack outside BUS is ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_done", {31'd0, done}, 32'd0);
        chk("stray_ack_rdata", rdata, 32'hFFFF_8001);

        // Timeout: no ack
        setop(1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'h0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_rdata_held", rdata, 32'hFFFF_8001);
        tick();

        // Ack on the 16th BUS cycle wins over timeout
        setop(1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'h0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("ack16_req", {31'd0, mem_req}, 32'd1);
            if (i == 15) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h55AA_55AA;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("ack16_done", {31'd0, done}, 32'd1);
        chk("ack16_err", {31'd0, err}, 32'd0);
        chk("ack16_rdata", rdata, 32'h55AA_55AA);
        tick();

        // Reset during BUS
        setop(1'b1, 1'b0, 3'b010, 32'h5000_0004, 32'h0);
        tick();
        start = 1'b0;
        chk("rb_req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rb_req_async", {31'd0, mem_req}, 32'd0);
        chk("rb_busy_async", {31'd0, busy}, 32'd0);
        chk("rb_done_async", {31'd0, done}, 32'd0);
        chk("rb_rdata_async", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        chk("rb_idle_req", {31'd0, mem_req}, 32'd0);
        chk("rb_idle_rdata", rdata, 32'h0);
        setop(1'b1, 1'b0, 3'b010, 32'h5000_0004, 32'h0);
        tick();
        start = 1'b0;
        chk("rb_lw_req", {31'd0, mem_req}, 32'd1);
        chk("rb_lw_addr", mem_addr, 32'h5000_0004);
        chk("rb_rdata_still0", rdata, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        chk("rb_lw_done", {31'd0, done}, 32'd1);
        chk("rb_lw_err", {31'd0, err}, 32'd0);
        chk("rb_lw_rdata", rdata, 32'h0BAD_F00D);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the ALU: takes the ALU result as the effective address, drives a request/acknowledge data bus, and returns sign/zero-extended load data for register write-back. It generates byte-lane enables, flags misaligned or illegal accesses, and aborts bus cycles that time out. While an access is in flight it asserts `busy` so the core holds its PC.

## Interface
- `N`, 32: data/address width; byte-lane logic is fixed at 4 lanes.
- `TIMEOUT`, 16: maximum BUS-state cycles without `mem_ack` before abort (≥2).

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: current instruction is a load/store; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only).
- `addr` in N: effective address (ALU result).
- `wdata` in N: store data (rs2).
- `rdata` out N: extended load result, registered.
- `busy` out 1: core stall request.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: misaligned/illegal/timeout; valid only with `done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out N, `mem_wdata` out N, `mem_be` out 4: bus request, registered.
- `mem_rdata` in N, `mem_ack` in 1: bus response.

## Operation
- States: IDLE, BUS, RESP. Reset → IDLE; all outputs 0, including `rdata` and timeout counter.
- IDLE, `start`=0: stay.
- IDLE, `start`=1, legal and aligned: latch `we`, `funct3`, `addr[1:0]`. Register the bus fields, set `mem_req`=1, go to BUS.
- IDLE, `start`=1, illegal or misaligned: go to RESP with `err`=1. No bus request is issued.
- Illegal encodings: store with `funct3` ∉ {000, 001, 010}; load with `funct3` ∈ {011, 110, 111}.
- Misaligned: h/hu with `addr[0]`=1; w with `addr[1:0]`≠00.
- Bus fields:
  - `mem_addr` = {`addr[N-1:2]`, 2'b00}.
  - `mem_we` = `we`.
  - `mem_be`: b = 4'b0001 << `addr[1:0]`; h = 4'b0011 << `addr[1:0]`; w = 4'b1111.
  - `mem_wdata`: b = {4{`wdata[7:0]`}}; h = {2{`wdata[15:0]`}}; w = `wdata`.
  - On loads, `mem_be` carries the access lanes as well.
- BUS: hold all bus outputs stable while `mem_ack`=0; the counter increments each cycle.
- BUS, `mem_ack`=1:
  - Drop `mem_req` and go to RESP with `err`=0.
  - Load: `rdata` ← `mem_rdata` >> (8·`addr[1:0]`), then sign-extend (b, h) or zero-extend (bu, hu) from bit 7/15; w passes through.
- BUS, counter = `TIMEOUT`−1 and `mem_ack`=0: drop `mem_req`, go to RESP with `err`=1.
- BUS, `mem_ack` on the same cycle as timeout: the ack wins, `err`=0.
- RESP: `done`=1 for exactly one cycle, then IDLE. `start` during RESP is ignored.
- `rdata` updates only on a successful load. It holds its value through stores, errors and IDLE.
- `mem_ack` outside BUS is ignored.

## Timing
- `busy` = (IDLE & `start`) | BUS. It is combinational, so the core stalls in the same cycle `start` rises. `busy`=0 in RESP, so the instruction commits at the RESP clock edge.
- Latency with zero-wait ack: `start` in cycle 0, `mem_req` and ack in cycle 1, `done`/`rdata` valid in cycle 2.
- Each additional wait cycle adds one cycle.
- Error detected in IDLE: `done`/`err` appear the next cycle.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then RESP.
- `reset` mid-access: `mem_req`, `done`, `busy` state and `err` clear immediately (asynchronously); FSM returns to IDLE. Any bus cycle in progress is abandoned.
- Back-to-back accesses: a new `start` is accepted in the IDLE cycle after RESP. Minimum spacing is 3 cycles.

## Test plan
- LW, addr=0x1000_0008, ack in first BUS cycle, `mem_rdata`=0xDEAD_BEEF:
  - `mem_addr`=0x1000_0008, `mem_be`=1111.
  - `done`=1 and `rdata`=0xDEAD_BEEF in cycle 2; `err`=0.
- LB/LBU, addr=0x…03, `mem_rdata`=0x80FF_0011 → `mem_be`=1000; LB `rdata`=0xFFFF_FF80, LBU `rdata`=0x0000_0080.
- SH, addr=0x…02, `wdata`=0x1234_ABCD, ack after 3 wait cycles:
  - `mem_wdata`=0xABCD_ABCD, `mem_be`=1100, `mem_we`=1.
  - Bus outputs stable for 4 cycles; `done` in cycle 5; `rdata` unchanged.
- Error detection with no bus traffic:
  - LW addr=0x…02: `mem_req` never rises; `done`=`err`=1 in cycle 1.
  - SB with `funct3`=100: same response.
- Timeout, `TIMEOUT`=16, ack never arrives:
  - `mem_req` high for 16 cycles, then `done`=`err`=1.
  - A repeat run with ack on the 16th cycle gives `err`=0.
- Reset asserted during BUS: `mem_req`=0 immediately, FSM back in IDLE. After release, a new LW completes normally and `rdata` holds 0 until then.
